// File: rtl/kanade_mem_pkg.sv
// kanade_mem_pkg
//   Shared definitions for the main-RAM port A arbiter:
//   - master index constants (M_CPU, M_DMA)
//   - default address/data widths
//   - request bundle typedef {we, addr, wdata, be}
//   - saturating 4-bit increment used by the burst counter
package kanade_mem_pkg;

   localparam logic M_CPU = 1'b0;
   localparam logic M_DMA = 1'b1;

   localparam int ADDR_W_DEF = 30;
   localparam int DATA_W_DEF = 32;
   localparam int BE_W_DEF   = DATA_W_DEF / 8;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
      logic [BE_W_DEF-1:0]   be;
   } mem_req_t;

   // Burst count never wraps: a long lone-requester run must still read as
   // "allowance exhausted" when the other master shows up.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      logic [3:0] r;
      if (v == 4'd15) begin
         r = 4'd15;
      end else begin
         r = v + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   One bus master's connection to the RAM port arbiter.
//   master modport: drives req/we/addr/wdata/be, receives gnt/rvalid/rdata.
//   slave modport : the arbiter side.
//   gnt is combinational (access accepted at the edge where req && gnt);
//   rvalid is high for one cycle, one cycle after an accepted read.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) ();

   logic                  req;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   be;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/ram_port_arbiter_rr_burst_picker.sv
// rr_burst_picker
//   Two-way round-robin pick with a bounded burst allowance.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     req[1:0]   : request per master (index = master number)
//     gnt[1:0]   : one-hot-or-zero grant, combinational, forced 0 in reset
//   State: owner (last granted master), burst_cnt (consecutive owner grants).
module rr_burst_picker
   import kanade_mem_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   generate
      if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
         $error("rr_burst_picker: BURST_MAX must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

   logic       owner_q, owner_d;
   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic       pick;
   logic       any_gnt;

   // Winner selection and next owner/count.
   always_comb begin
      pick        = owner_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      gnt         = 2'b00;

      case (req)
         2'b00:   pick = owner_q;
         2'b01:   pick = M_CPU;
         2'b10:   pick = M_DMA;
         // Contention: the owner keeps the port until its allowance runs out.
         2'b11:   pick = (burst_cnt_q < BURST_LIM) ? owner_q : ~owner_q;
         default: pick = owner_q;
      endcase

      any_gnt = (req != 2'b00) && rst_n;

      if (any_gnt) begin
         gnt = (pick == M_DMA) ? 2'b10 : 2'b01;
         if (pick == owner_q) begin
            burst_cnt_d = sat_inc4(burst_cnt_q);
         end else begin
            owner_d     = pick;
            burst_cnt_d = 4'd1;
         end
      end else begin
         gnt         = 2'b00;
         owner_d     = owner_q;
         burst_cnt_d = burst_cnt_q;
      end
   end

   // Owner and burst counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q     <= M_CPU;
         burst_cnt_q <= 4'd0;
      end else begin
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares RAM port A between M0 (CPU data) and M1 (boot loader/DMA),
//   one access per cycle, round-robin with a burst allowance.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     m0, m1       : master buses (ram_port_arbiter_if.slave)
//     ram_wren     : RAM write enable (0 when nothing is granted)
//     ram_address  : RAM word address (muxed from the granted master)
//     ram_data     : RAM write data
//     ram_byteena  : RAM byte enables
//     ram_q        : RAM read data, valid the cycle after the address edge
module ram_port_arbiter
   import kanade_mem_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   ram_port_arbiter_if.slave   m0,
   ram_port_arbiter_if.slave   m1,
   output logic                ram_wren,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W-1:0]   ram_data,
   output logic [DATA_W/8-1:0] ram_byteena,
   input  logic [DATA_W-1:0]   ram_q
);

   logic [1:0] req_s;
   logic [1:0] gnt_s;
   logic [1:0] rd_pend_q, rd_pend_d;

   assign req_s = {m1.req, m0.req};

   rr_burst_picker #(
      .BURST_MAX (BURST_MAX)
   ) u_picker (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_s),
      .gnt   (gnt_s)
   );

   assign m0.gnt = gnt_s[0];
   assign m1.gnt = gnt_s[1];

   // RAM port mux; address/data/be are don't-care without a grant, so M0 is
   // the idle default and only wren needs qualifying.
   always_comb begin
      ram_address = m0.addr;
      ram_data    = m0.wdata;
      ram_byteena = m0.be;
      if (gnt_s[1]) begin
         ram_address = m1.addr;
         ram_data    = m1.wdata;
         ram_byteena = m1.be;
      end else begin
         ram_address = m0.addr;
         ram_data    = m0.wdata;
         ram_byteena = m0.be;
      end
      ram_wren = (gnt_s[0] & m0.we) | (gnt_s[1] & m1.we);
   end

   // Next read-pending flags: set for an accepted read only.
   always_comb begin
      rd_pend_d    = 2'b00;
      rd_pend_d[0] = gnt_s[0] & ~m0.we;
      rd_pend_d[1] = gnt_s[1] & ~m1.we;
   end

   // Read-pending registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pend_q <= 2'b00;
      end else begin
         rd_pend_q <= rd_pend_d;
      end
   end

   // Qualified by rst_n so a read accepted just before reset never returns.
   assign m0.rvalid = rd_pend_q[0] & rst_n;
   assign m1.rvalid = rd_pend_q[1] & rst_n;
   assign m0.rdata  = ram_q;
   assign m1.rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed bench for ram_port_arbiter with a small behavioural RAM
//   (registered address, combinational q, byte-enable writes).
module tb_ram_port_arbiter;
   import kanade_mem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ram_wren;
   logic [29:0] ram_address;
   logic [31:0] ram_data;
   logic [3:0]  ram_byteena;
   logic [31:0] ram_q;

   int checks   = 0;
   int failures = 0;

   ram_port_arbiter_if #(.ADDR_W(30), .DATA_W(32)) m0_if ();
   ram_port_arbiter_if #(.ADDR_W(30), .DATA_W(32)) m1_if ();

   ram_port_arbiter #(
      .ADDR_W    (30),
      .DATA_W    (32),
      .BURST_MAX (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .ram_wren    (ram_wren),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_byteena (ram_byteena),
      .ram_q       (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM, port A.
   logic [31:0] mem [0:255];
   logic [29:0] addr_q;

   always @(posedge clk) begin
      if (ram_wren) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_byteena[b]) mem[ram_address[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
         end
      end
      addr_q <= ram_address;
   end

   assign ram_q = mem[addr_q[7:0]];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_m0(input logic req, input mem_req_t r);
      m0_if.req   = req;
      m0_if.we    = r.we;
      m0_if.addr  = r.addr;
      m0_if.wdata = r.wdata;
      m0_if.be    = r.be;
   endtask

   task automatic drive_m1(input logic req, input mem_req_t r);
      m1_if.req   = req;
      m1_if.we    = r.we;
      m1_if.addr  = r.addr;
      m1_if.wdata = r.wdata;
      m1_if.be    = r.be;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic mem_req_t mk(input logic we, input logic [29:0] a,
                                   input logic [31:0] d, input logic [3:0] be);
      mem_req_t r;
      r.we = we; r.addr = a; r.wdata = d; r.be = be;
      return r;
   endfunction

   initial begin
      logic prev0, prev1, exp1;

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h20] = 32'h11223344;
      mem[8'h30] = 32'h55AA55AA;

      // Reset with both masters requesting writes: everything stays quiet.
      rst_n = 1'b0;
      drive_m0(1'b1, mk(1'b1, 30'h3F, 32'h0, 4'hF));
      drive_m1(1'b1, mk(1'b1, 30'h3F, 32'h0, 4'hF));
      next_cycle();
      @(negedge clk);
      check_eq("rst_m0_gnt", m0_if.gnt, 1'b0);
      check_eq("rst_m1_gnt", m1_if.gnt, 1'b0);
      check_eq("rst_wren", ram_wren, 1'b0);
      check_eq("rst_m0_rvalid", m0_if.rvalid, 1'b0);
      check_eq("rst_m1_rvalid", m1_if.rvalid, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      drive_m0(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      drive_m1(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      next_cycle();

      // Single read by M0.
      drive_m0(1'b1, mk(1'b0, 30'h10, 32'h0, 4'hF));
      @(negedge clk);
      check_eq("rd_m0_gnt", m0_if.gnt, 1'b1);
      check_eq("rd_m1_gnt", m1_if.gnt, 1'b0);
      check_eq("rd_wren", ram_wren, 1'b0);
      check_eq("rd_addr", ram_address, 30'h10);
      next_cycle();
      drive_m0(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      @(negedge clk);
      check_eq("rd_m0_rvalid", m0_if.rvalid, 1'b1);
      check_eq("rd_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
      check_eq("rd_m1_rvalid", m1_if.rvalid, 1'b0);
      check_eq("rd_m0_gnt_idle", m0_if.gnt, 1'b0);
      next_cycle();

      // Byte-enable write by M1 then read-back on the next cycle.
      drive_m1(1'b1, mk(1'b1, 30'h20, 32'hAABBCCDD, 4'b0101));
      @(negedge clk);
      check_eq("bew_m1_gnt", m1_if.gnt, 1'b1);
      check_eq("bew_wren", ram_wren, 1'b1);
      check_eq("bew_be", ram_byteena, 4'b0101);
      check_eq("bew_data", ram_data, 32'hAABBCCDD);
      next_cycle();
      drive_m1(1'b1, mk(1'b0, 30'h20, 32'h0, 4'hF));
      @(negedge clk);
      check_eq("bew_rd_gnt", m1_if.gnt, 1'b1);
      check_eq("bew_rd_wren", ram_wren, 1'b0);
      check_eq("bew_no_wr_rvalid", m1_if.rvalid, 1'b0);
      next_cycle();
      drive_m1(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      @(negedge clk);
      check_eq("bew_rvalid", m1_if.rvalid, 1'b1);
      check_eq("bew_rdata", m1_if.rdata, 32'h11BB33DD);
      next_cycle();

      // Reset mid-read: accepted read, then reset during the rvalid cycle.
      drive_m0(1'b1, mk(1'b0, 30'h10, 32'h0, 4'hF));
      @(negedge clk);
      check_eq("rmr_m0_gnt", m0_if.gnt, 1'b1);
      next_cycle();
      rst_n = 1'b0;
      drive_m0(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      drive_m1(1'b1, mk(1'b1, 30'h3F, 32'h0, 4'hF));
      @(negedge clk);
      check_eq("rmr_m0_rvalid", m0_if.rvalid, 1'b0);
      check_eq("rmr_wren", ram_wren, 1'b0);
      check_eq("rmr_m1_gnt", m1_if.gnt, 1'b0);
      next_cycle();
      rst_n = 1'b1;

      // Contention from reset: M0 x4, M1 x4, M0 x4, reads from both.
      drive_m0(1'b1, mk(1'b0, 30'h10, 32'h0, 4'hF));
      drive_m1(1'b1, mk(1'b0, 30'h20, 32'h0, 4'hF));
      prev0 = 1'b0;
      prev1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         exp1 = ((i / 4) % 2) == 1;
         @(negedge clk);
         check_eq($sformatf("ct%0d_m0_gnt", i), m0_if.gnt, !exp1);
         check_eq($sformatf("ct%0d_m1_gnt", i), m1_if.gnt, exp1);
         check_eq($sformatf("ct%0d_m0_rvalid", i), m0_if.rvalid, prev0);
         check_eq($sformatf("ct%0d_m1_rvalid", i), m1_if.rvalid, prev1);
         if (prev0) check_eq($sformatf("ct%0d_m0_rdata", i), m0_if.rdata, 32'hDEADBEEF);
         if (prev1) check_eq($sformatf("ct%0d_m1_rdata", i), m1_if.rdata, 32'h11BB33DD);
         next_cycle();
         prev0 = !exp1;
         prev1 = exp1;
      end
      drive_m0(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      drive_m1(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      @(negedge clk);
      check_eq("ct_last_m0_rvalid", m0_if.rvalid, 1'b1);
      check_eq("ct_last_m1_rvalid", m1_if.rvalid, 1'b0);
      next_cycle();

      // Lone requester M1 for 10 cycles, then M0 joins and wins.
      drive_m1(1'b1, mk(1'b0, 30'h20, 32'h0, 4'hF));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq($sformatf("lone%0d_m1_gnt", i), m1_if.gnt, 1'b1);
         check_eq($sformatf("lone%0d_m0_gnt", i), m0_if.gnt, 1'b0);
         next_cycle();
      end
      drive_m0(1'b1, mk(1'b0, 30'h10, 32'h0, 4'hF));
      @(negedge clk);
      check_eq("lone_join_m0_gnt", m0_if.gnt, 1'b1);
      check_eq("lone_join_m1_gnt", m1_if.gnt, 1'b0);
      next_cycle();
      drive_m0(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      drive_m1(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      next_cycle();

      // Zero-byte-enable write by M0, then read-back.
      drive_m0(1'b1, mk(1'b1, 30'h30, 32'h00000000, 4'b0000));
      @(negedge clk);
      check_eq("zbe_m0_gnt", m0_if.gnt, 1'b1);
      check_eq("zbe_wren", ram_wren, 1'b1);
      next_cycle();
      drive_m0(1'b1, mk(1'b0, 30'h30, 32'h0, 4'hF));
      @(negedge clk);
      check_eq("zbe_rd_gnt", m0_if.gnt, 1'b1);
      next_cycle();
      drive_m0(1'b0, mk(1'b0, 30'h0, 32'h0, 4'h0));
      @(negedge clk);
      check_eq("zbe_rvalid", m0_if.rvalid, 1'b1);
      check_eq("zbe_rdata", m0_if.rdata, 32'h55AA55AA);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single read/write port A of the main RAM between two bus masters: M0, the CPU data port, and M1, the boot loader/DMA.
- Arbitration is round-robin with a bounded burst allowance. The port runs pipelined at one access per cycle.
- Sits between the CPU/DMA buses and RAM port A. Port B (instruction fetch) is untouched.

Parameters:
- ADDR_W, 30, word-address width; matches the RAM address bus.
- DATA_W, 32, data width; byte enables are DATA_W/8.
- BURST_MAX, 4, maximum consecutive grants to one master while the other master is requesting; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- m0_req  in  1  M0 access request; held until granted.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  ADDR_W  M0 word address.
- m0_wdata  in  DATA_W  M0 write data.
- m0_be  in  4  M0 byte enables.
- m0_gnt  out  1  combinational; access accepted at this edge.
- m0_rvalid  out  1  read data valid; one cycle after the accepted read.
- m0_rdata  out  DATA_W  read data, qualified by m0_rvalid.
- m1_*  same set as m0_*, for M1.
- ram_wren  out  1  to RAM wren.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_byteena  out  4  to RAM byteena_a.
- ram_q  in  DATA_W  from RAM q; combinational from the RAM's registered address.

Behaviour:
- **State:** owner (1 bit, last granted master); burst_cnt (4 bits); rd_pend[1:0] (registered read-issued flags).
- **Grant decision** (combinational, each cycle):
  - Neither master requesting: no grant.
  - Exactly one requesting: that master is granted.
  - Both requesting: owner is granted if burst_cnt < BURST_MAX; otherwise the non-owner is granted.
- **Grant rules:**
  - At most one gnt is high per cycle.
  - A master's gnt is never high without its req.
  - The access is accepted at the edge where req && gnt.
- **RAM drive:**
  - ram_address, ram_data and ram_byteena are muxed from the granted master; they are don't-care when there is no grant.
  - ram_wren = granted master's we; it is 0 when there is no grant.
- **Counter update on a grant:**
  - Grant to owner: burst_cnt = min(burst_cnt+1, 15).
  - Grant to non-owner: owner flips, burst_cnt = 1.
  - No grant: owner and burst_cnt hold.
  - A lone requester keeps winning regardless of burst_cnt. The count limits only contention.
- **Read latency 1:**
  - An accepted read at edge N sets rd_pend[i]. mX_rvalid = rd_pend[i] during cycle N+1.
  - mX_rdata = ram_q, passed through unregistered.
  - rdata is don't-care when rvalid is low; the RAM mux output drives both rdata lines.
- **Writes:**
  - Commit at the accepting edge. No write response is generated.
  - be=4'b0000 is still granted and sets wren=1; memory is unchanged.
- **Back-to-back:**
  - A new access may be granted in the cycle the previous rvalid is high. Full throughput is 1 access/cycle.
  - Write then read to the same address on the next cycle returns the newly written data.
- **Reset:**
  - While rst_n=0: all gnt=0, ram_wren=0, both rvalid=0.
  - Reset sets owner=M0, burst_cnt=0, rd_pend=0.
  - A read accepted in the cycle before reset asserts produces no rvalid.
  - After release, the first contention is won by M0.
- **Illegal configuration:** BURST_MAX=0 is illegal; an elaboration-time check must fire.

Decomposition:
- Shared package (kanade_mem_pkg):
  - Master index constants M_CPU=0 and M_DMA=1.
  - Default ADDR_W/DATA_W.
  - A request-bundle typedef {we, addr, wdata, be}.
- One natural sub-module, rr_burst_picker: combinational 2-way pick plus the owner/burst_cnt registers. The top level holds the muxes and the rd_pend logic.

Test Plan:
- **Single read:** preload RAM[0x10]=0xDEADBEEF; M0 reads 0x10 alone -> m0_gnt same cycle, m0_rvalid next cycle with m0_rdata=0xDEADBEEF, m1 signals quiet.
- **Byte-enable write:** RAM[0x20]=0x11223344; M1 writes 0xAABBCCDD with be=4'b0101, then reads 0x20 on the next cycle -> rdata=0x11BB33DD on the cycle after the read.
- **Contention bursting (BURST_MAX=4):**
  - Both masters hold req continuously from reset -> grant sequence M0×4, M1×4, M0×4.
  - Never two gnts in one cycle.
  - Each rvalid appears exactly one cycle after its own grant.
- **Lone requester:** only M1 requests for 10 cycles -> 10 consecutive grants. M0 then raises req -> M0 granted next, because burst_cnt≥BURST_MAX.
- **Reset mid-read:** M0 read accepted at edge N, rst_n low during cycle N+1 -> m0_rvalid stays 0 and ram_wren=0. After release, both masters requesting -> M0 wins first.
- **Zero-byte-enable write:** M0 writes with be=0 to 0x30 holding 0x55AA55AA -> granted with ram_wren=1; a later read returns 0x55AA55AA.
